// File: rtl/wb_timer_pkg.sv
// Shared types, reset values and byte-merge helper for the Wishbone machine timer.
package wb_timer_pkg;

    // Register selected by adr[3:2]
    typedef enum logic [1:0] {
        MTIME_LO    = 2'd0,
        MTIME_HI    = 2'd1,
        MTIMECMP_LO = 2'd2,
        MTIMECMP_HI = 2'd3
    } reg_e;

    localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte-masked merge: lanes with sel[i] set take new_val, others keep old_val
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/if_wb.sv
// Wishbone B4 pipelined bus bundle.
// clk, rst: bus clock and asynchronous active-high reset.
// slave modport: adr/dat_i/sel/we/cyc/stb in, dat_o/ack/err/stall out.
interface if_wb (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        stall;

    modport slave (
        input  clk, rst, adr, dat_i, sel, we, cyc, stb,
        output dat_o, ack, err, stall
    );

    modport master (
        input  clk, rst, dat_o, ack, err, stall,
        output adr, dat_i, sel, we, cyc, stb
    );
endinterface

// File: rtl/wb_timer.sv
// RISC-V machine timer (64-bit mtime/mtimecmp) behind a Wishbone B4 pipelined slave port.
// Ports:
//   wb        - Wishbone slave (clk, rst, adr, dat_i, sel, we, cyc, stb -> dat_o, ack, err, stall)
//   timer_irq - level interrupt, registered (mtime >= mtimecmp)
// Parameters:
//   PRESCALE  - clock cycles per mtime increment (1..65535)
//   ADR_WIDTH - address bits decoded inside the slave window
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned ADR_WIDTH = 14
) (
    if_wb.slave  wb,
    output logic timer_irq
);

    localparam int unsigned       PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt, pcnt_d;
    logic [63:0]       mtime, mtime_d;
    logic [63:0]       mtimecmp, mtimecmp_d;
    logic [31:0]       hi_shadow, hi_shadow_d;
    logic [31:0]       dat_q, dat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              access, bad, wr, rd, tick;
    reg_e              idx;

    // Address bits above the decoded window belong to the interconnect
    if (ADR_WIDTH < 32) begin : g_adr_unused
        logic adr_unused;
        assign adr_unused = ^wb.adr[31:ADR_WIDTH];
    end

    // Access decode and prescaler tick
    always_comb begin
        access = wb.cyc & wb.stb;
        bad    = (wb.adr[1:0] != 2'b00) | (|wb.adr[ADR_WIDTH-1:4]);
        wr     = access & ~bad & wb.we;
        rd     = access & ~bad & ~wb.we;
        idx    = reg_e'(wb.adr[3:2]);
        tick   = (pcnt == PCNT_MAX);
        pcnt_d = tick ? '0 : pcnt + PCNT_W'(1);
    end

    // Next register state and response; a write to either mtime half overrides the tick
    always_comb begin
        mtime_d     = tick ? mtime + 64'd1 : mtime;
        mtimecmp_d  = mtimecmp;
        hi_shadow_d = hi_shadow;
        dat_d       = '0;
        ack_d       = access & ~bad;
        err_d       = access & bad;

        if (wr) begin
            case (idx)
                MTIME_LO:    mtime_d = {mtime[63:32], apply_sel(mtime[31:0], wb.dat_i, wb.sel)};
                MTIME_HI:    mtime_d = {apply_sel(mtime[63:32], wb.dat_i, wb.sel), mtime[31:0]};
                MTIMECMP_LO: mtimecmp_d[31:0]  = apply_sel(mtimecmp[31:0], wb.dat_i, wb.sel);
                MTIMECMP_HI: mtimecmp_d[63:32] = apply_sel(mtimecmp[63:32], wb.dat_i, wb.sel);
                default:     mtimecmp_d = mtimecmp;
            endcase
        end

        // Reading lo snapshots hi so a following hi read is coherent with it
        if (rd) begin
            case (idx)
                MTIME_LO: begin
                    dat_d       = mtime[31:0];
                    hi_shadow_d = mtime[63:32];
                end
                MTIME_HI:    dat_d = hi_shadow;
                MTIMECMP_LO: dat_d = mtimecmp[31:0];
                MTIMECMP_HI: dat_d = mtimecmp[63:32];
                default:     dat_d = '0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            pcnt      <= '0;
            mtime     <= MTIME_RST;
            mtimecmp  <= MTIMECMP_RST;
            hi_shadow <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            pcnt      <= pcnt_d;
            mtime     <= mtime_d;
            mtimecmp  <= mtimecmp_d;
            hi_shadow <= hi_shadow_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    // Responses are dropped if the master abandons the cycle
    assign wb.ack   = ack_q & wb.cyc;
    assign wb.err   = err_q & wb.cyc;
    assign wb.dat_o = (ack_q & wb.cyc) ? dat_q : '0;
    assign wb.stall = 1'b0;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: per-cycle comparison against a behavioural
// model plus directed accesses with hand-computed expected values.
module tb_wb_timer;

    localparam int P  = 4;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timer_irq;

    if_wb bus (.clk(clk), .rst(rst));

    wb_timer #(.PRESCALE(P), .ADR_WIDTH(AW)) dut (
        .wb        (bus.slave),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [63:0] m_time  = 64'h0;
    logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [31:0] m_shad  = 32'h0;
    logic [31:0] m_dat   = 32'h0;
    logic        m_ack   = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_irq   = 1'b0;
    int          k       = 0;
    logic        mm_acc, mm_bad, mm_tick;
    logic [1:0]  mm_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference model: mtime counts cycles since reset / P, writes override whole register
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_time = 64'h0;
                m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
                m_shad = 32'h0;
                m_dat  = 32'h0;
                m_ack  = 1'b0;
                m_err  = 1'b0;
                m_irq  = 1'b0;
                k      = 0;
            end else begin
                mm_tick = ((k % P) == P - 1);
                k++;
                m_irq  = (m_time >= m_cmp);
                mm_acc = bus.cyc & bus.stb;
                mm_bad = (bus.adr[1:0] != 2'b00) || (bus.adr[AW-1:4] != '0);
                m_ack  = mm_acc & ~mm_bad;
                m_err  = mm_acc & mm_bad;
                m_dat  = 32'h0;
                mm_r   = bus.adr[3:2];
                if (m_ack && !bus.we) begin
                    case (mm_r)
                        2'd0: begin m_dat = m_time[31:0]; m_shad = m_time[63:32]; end
                        2'd1: m_dat = m_shad;
                        2'd2: m_dat = m_cmp[31:0];
                        default: m_dat = m_cmp[63:32];
                    endcase
                end
                if (m_ack && bus.we) begin
                    case (mm_r)
                        2'd0: m_time[31:0]  = merge(m_time[31:0], bus.dat_i, bus.sel);
                        2'd1: m_time[63:32] = merge(m_time[63:32], bus.dat_i, bus.sel);
                        2'd2: m_cmp[31:0]   = merge(m_cmp[31:0], bus.dat_i, bus.sel);
                        default: m_cmp[63:32] = merge(m_cmp[63:32], bus.dat_i, bus.sel);
                    endcase
                end
                if (mm_tick && !(m_ack && bus.we && mm_r < 2'd2)) m_time = m_time + 64'd1;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("ack",   64'(bus.ack),   64'(m_ack & bus.cyc));
                check("err",   64'(bus.err),   64'(m_err & bus.cyc));
                check("dat_o", 64'(bus.dat_o), 64'((m_ack & bus.cyc) ? m_dat : 32'h0));
                check("irq",   64'(timer_irq), 64'(m_irq));
                check("stall", 64'(bus.stall), 64'h0);
            end
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w;
        bus.adr = a; bus.dat_i = d; bus.sel = s;
    endtask

    task automatic idle_stb();
        bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    // Issue now (just after an edge), capture the response cycle
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rv,
                         output logic ak, output logic er);
        drive(w, a, d, s);
        @(posedge clk); #1;
        idle_stb();
        @(negedge clk);
        rv = bus.dat_o; ak = bus.ack; er = bus.err;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rv,
                        output logic ak, output logic er);
        @(posedge clk); #1;
        issue(w, a, d, s, rv, ak, er);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rv; logic ak, er;
        xfer(1'b1, a, d, 4'hF, rv, ak, er);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rv; logic ak, er;
        xfer(1'b0, a, 32'h0, 4'hF, rv, ak, er);
        check({name, "_ack"}, 64'(ak), 64'h1);
        check(name, 64'(rv), 64'(exp));
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        logic        ak, er, seen;
        logic [31:0] b2b_adr [4];
        logic [31:0] b2b_exp [4];

        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0; bus.dat_i = '0; bus.sel = '0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        reset_release();

        // Reset defaults
        check("rst_irq", 64'(timer_irq), 64'h0);
        rd_chk("rst_mtime_lo", 32'h0, 32'h0);
        rd_chk("rst_mtime_hi", 32'h4, 32'h0);
        rd_chk("rst_cmp_lo",   32'h8, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_hi",   32'hC, 32'hFFFF_FFFF);

        // Byte-masked write, and sel = 0 leaves the register alone
        xfer(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, rv, ak, er);
        check("sel_wr_ack", 64'(ak), 64'h1);
        rd_chk("sel_cmp_lo", 32'h8, 32'hFFBB_FFDD);
        xfer(1'b1, 32'hC, 32'h1234_5678, 4'b0000, rv, ak, er);
        check("sel0_ack", 64'(ak), 64'h1);
        rd_chk("sel0_cmp_hi", 32'hC, 32'hFFFF_FFFF);

        // Count with carry; lo write lands on a tick edge so that increment is lost
        wr(32'h4, 32'h0);
        do begin @(posedge clk); #1; end while ((k % P) != P - 1);
        drive(1'b1, 32'h0, 32'hFFFF_FFFE, 4'hF);
        @(posedge clk); #1;
        idle_stb();
        repeat (12) @(posedge clk);
        #1;
        issue(1'b0, 32'h0, 32'h0, 4'hF, rv, ak, er);
        check("count_lo", 64'(rv), 64'h1);
        repeat (5) @(posedge clk);
        rd_chk("count_hi_shadow", 32'h4, 32'h1);

        // Interrupt rise at mtime == 0x10
        wr(32'h4, 32'h0);
        wr(32'h0, 32'h0);
        wr(32'h8, 32'h10);
        wr(32'hC, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (timer_irq) seen = 1'b1;
        end
        check("irq_rise_seen", 64'(seen), 64'h1);
        rd_chk("irq_rise_mtime", 32'h0, 32'h10);

        // Interrupt drop two cycles after the cmp_hi write is accepted
        @(posedge clk); #1;
        drive(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        idle_stb();
        @(negedge clk);
        check("irq_hold_n1", 64'(timer_irq), 64'h1);
        @(negedge clk);
        check("irq_drop_n2", 64'(timer_irq), 64'h0);

        // Error decode: no side effects, zero data
        xfer(1'b0, 32'h2, 32'h0, 4'hF, rv, ak, er);
        check("err_misalign", 64'(er), 64'h1);
        check("err_misalign_ack", 64'(ak), 64'h0);
        check("err_misalign_dat", 64'(rv), 64'h0);
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rv, ak, er);
        check("err_range", 64'(er), 64'h1);
        xfer(1'b1, 32'h18, 32'h1234_5678, 4'hF, rv, ak, er);
        check("err_range_cmp", 64'(er), 64'h1);
        rd_chk("err_no_effect", 32'h8, 32'h10);

        // Four back-to-back reads, one ack per cycle in order
        b2b_adr[0] = 32'h8; b2b_exp[0] = 32'h10;
        b2b_adr[1] = 32'hC; b2b_exp[1] = 32'hFFFF_FFFF;
        b2b_adr[2] = 32'h0; b2b_exp[2] = 32'h0;
        b2b_adr[3] = 32'h4; b2b_exp[3] = 32'h0;
        @(posedge clk); #1;
        drive(1'b0, b2b_adr[0], 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) drive(1'b0, b2b_adr[i+1], 32'h0, 4'hF);
            else idle_stb();
            @(negedge clk);
            check("b2b_ack", 64'(bus.ack), 64'h1);
            if (i != 2) check("b2b_dat", 64'(bus.dat_o), 64'(b2b_exp[i]));
        end

        // Abort: cyc dropped in the response cycle, write still applied
        @(posedge clk); #1;
        drive(1'b1, 32'h8, 32'h55, 4'hF);
        @(posedge clk); #1;
        idle_stb();
        bus.cyc = 1'b0;
        @(negedge clk);
        check("abort_no_ack", 64'(bus.ack), 64'h0);
        rd_chk("abort_applied", 32'h8, 32'h55);

        // Reset in the middle of a burst
        wr(32'hC, 32'h0);
        wr(32'h4, 32'h1);
        @(posedge clk); #1;
        drive(1'b0, 32'h8, 32'h0, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 32'hC, 32'h0, 4'hF);
        check("pre_rst_irq", 64'(timer_irq), 64'h1);
        #2 rst = 1'b1;
        #1;
        idle_stb();
        check("rst_ack_now", 64'(bus.ack),   64'h0);
        check("rst_err_now", 64'(bus.err),   64'h0);
        check("rst_dat_now", 64'(bus.dat_o), 64'h0);
        check("rst_irq_now", 64'(timer_irq), 64'h0);
        reset_release();
        rd_chk("rst2_mtime_lo", 32'h0, 32'h0);
        rd_chk("rst2_mtime_hi", 32'h4, 32'h0);
        rd_chk("rst2_cmp_lo",   32'h8, 32'hFFFF_FFFF);
        rd_chk("rst2_cmp_hi",   32'hC, 32'hFFFF_FFFF);

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) != 0) begin
                bus.cyc   = 1'b1;
                bus.stb   = 1'b1;
                bus.we    = 1'($urandom_range(0, 1));
                bus.adr   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 63))
                                                         : 32'($urandom_range(0, 3) * 4);
                bus.dat_i = $urandom;
                bus.sel   = 4'($urandom_range(0, 15));
                if (bus.we && bus.adr[3:2] == 2'd1) bus.dat_i = 32'($urandom_range(0, 1));
            end else begin
                idle_stb();
                bus.cyc = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        idle_stb();
        bus.cyc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
